his_frame_scheduler: RTL

- Frame-level controller for the shared histogram dual-port RAM: port A writes, port B reads, 1-cycle read latency.
- Sequences each frame as CLEAR (zero every bin), ACQ (RAM granted to the histogram builder for N laser shots), DRAIN, then SCAN/EMIT (per-pixel peak search).
- Owns the RAM port mux, so the builder, clear sweep and peak search never drive the RAM at the same time.
- Peaks leave on a valid/ready stream toward the TDC/readout side.

---
 rtl/his_frame_scheduler.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/his_frame_scheduler.sv
// Frame controller for the shared histogram RAM: CLEAR -> ACQ -> DRAIN -> SCAN/EMIT -> DONE.
// Owns the RAM port mux and streams one peak (pixel, bin, count) per pixel on a valid/ready output.
module his_frame_scheduler #(
  parameter int NB    = 6,
  parameter int PIX_W = 2,
  parameter int CNT_W = 8,
  parameter int ACQ_W = 16,
  localparam int RAM_ADDR = PIX_W + NB
) (
  input  logic                clk,
  input  logic                res,
  input  logic                start,
  input  logic [ACQ_W-1:0]    acq_num,
  output logic                busy,
  output logic                frame_done,
  output logic                bld_en,
  input  logic                bld_shot_done,
  input  logic                bld_busy,
  input  logic [RAM_ADDR-1:0] bld_waddr,
  input  logic [CNT_W-1:0]    bld_wdata,
  input  logic                bld_wen,
  input  logic [RAM_ADDR-1:0] bld_raddr,
  input  logic                bld_ren,
  output logic [RAM_ADDR-1:0] ram_waddr,
  output logic [CNT_W-1:0]    ram_wdata,
  output logic                ram_wen,
  output logic [RAM_ADDR-1:0] ram_raddr,
  output logic                ram_ren,
  input  logic [CNT_W-1:0]    ram_rdata,
  output logic                peak_valid,
  input  logic                peak_ready,
  output logic [PIX_W-1:0]    peak_pix,
  output logic [NB-1:0]       peak_bin,
  output logic [CNT_W-1:0]    peak_cnt,
  output logic [2:0]          dbgState
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ACQ   = 3'd2,
    DRAIN = 3'd3,
    SCAN  = 3'd4,
    EMIT  = 3'd5,
    DONE  = 3'd6
  } stateT;

  stateT                state, stateNext;
  logic [ACQ_W-1:0]     acqNum;
  logic [ACQ_W-1:0]     shotCnt;
  logic [RAM_ADDR-1:0]  addrCnt;
  logic [PIX_W-1:0]     pix;
  logic [NB:0]          scanCyc;
  logic [CNT_W-1:0]     maxCnt;
  logic [NB-1:0]        maxBin;
  logic                 lastShot;

  // Peak stream handshake: a result transfers on a cycle where peak_valid and
  // peak_ready are both high; payload is held stable until that cycle.
  assign peak_pix = pix;
  assign peak_bin = maxBin;
  assign peak_cnt = maxCnt;
  assign dbgState = state;

  // acq_num = 0 still spends one ACQ cycle; otherwise leave on the final shot pulse
  assign lastShot = (acqNum == '0) ||
                    (bld_shot_done && ((shotCnt + ACQ_W'(1)) == acqNum));

  always_comb begin
    stateNext  = state;
    busy       = (state != IDLE);
    frame_done = 1'b0;
    bld_en     = 1'b0;
    ram_waddr  = '0;
    ram_wdata  = '0;
    ram_wen    = 1'b0;
    ram_raddr  = '0;
    ram_ren    = 1'b0;
    peak_valid = 1'b0;
    case (state)
      IDLE: begin
        if (start) stateNext = CLEAR;
      end
      CLEAR: begin
        ram_wen   = 1'b1;
        ram_waddr = addrCnt;
        if (addrCnt == '1) stateNext = ACQ;
      end
      ACQ: begin
        bld_en    = 1'b1;
        ram_waddr = bld_waddr;
        ram_wdata = bld_wdata;
        ram_wen   = bld_wen;
        ram_raddr = bld_raddr;
        ram_ren   = bld_ren;
        if (lastShot) stateNext = DRAIN;
      end
      DRAIN: begin
        ram_waddr = bld_waddr;
        ram_wdata = bld_wdata;
        ram_wen   = bld_wen;
        ram_raddr = bld_raddr;
        ram_ren   = bld_ren;
        if (!bld_busy) stateNext = SCAN;
      end
      SCAN: begin
        ram_ren   = !scanCyc[NB];
        ram_raddr = {pix, scanCyc[NB-1:0]};
        if (scanCyc[NB]) stateNext = EMIT;
      end
      EMIT: begin
        peak_valid = 1'b1;
        if (peak_ready) stateNext = (pix == '1) ? DONE : SCAN;
      end
      DONE: begin
        frame_done = 1'b1;
        stateNext  = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state   <= IDLE;
      acqNum  <= '0;
      shotCnt <= '0;
      addrCnt <= '0;
      pix     <= '0;
      scanCyc <= '0;
      maxCnt  <= '0;
      maxBin  <= '0;
    end else begin
      state <= stateNext;
      case (state)
        IDLE: begin
          if (start) begin
            acqNum  <= acq_num;
            addrCnt <= '0;
          end
        end
        CLEAR: begin
          addrCnt <= addrCnt + RAM_ADDR'(1);
          shotCnt <= '0;
        end
        ACQ: begin
          if (bld_shot_done && (shotCnt != acqNum)) shotCnt <= shotCnt + ACQ_W'(1);
        end
        DRAIN: begin
          if (!bld_busy) begin
            pix     <= '0;
            scanCyc <= '0;
          end
        end
        SCAN: begin
          scanCyc <= scanCyc + (NB+1)'(1);
          // read data lags the address by one cycle, so it belongs to bin scanCyc-1
          if (scanCyc != '0) begin
            if ((scanCyc == (NB+1)'(1)) || (ram_rdata > maxCnt)) begin
              maxCnt <= ram_rdata;
              maxBin <= scanCyc[NB-1:0] - NB'(1);
            end
          end
        end
        EMIT: begin
          if (peak_ready && (pix != '1)) begin
            pix     <= pix + PIX_W'(1);
            scanCyc <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
